imager_roi_crop: RTL and testbench

Region-of-interest crop stage placed directly downstream of the imager receive stage in the image pipeline. It consumes the typed `dvi/dtypei/datai` stream (`DTYPE_*` codes from `dtypes.v`) and forwards it unchanged except for three things:
- pixels outside a programmable row/column window are dropped;
- row markers for rows outside the window are dropped;
- row-start indices are renumbered to window-relative values.

Frame, header and unknown data types always pass through. Downstream stages therefore see a smaller, self-consistent image.

---
 rtl/imager_roi_crop.sv | 184 ++++++++++++++++++
 tb/tb_imager_roi_crop.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imager_roi_crop.sv
// imager_roi_crop: region-of-interest crop for the typed dvi/dtypei/datai
// image stream. Pixels and row markers outside a programmable window are
// dropped and row-start indices are renumbered window-relative; frame,
// header and unknown types always pass. One cycle of latency, no stalls.
module imager_roi_crop #(
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 16,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clki,
  input  logic                   resetb_clki,
  input  logic                   enable,
  input  logic [DIM_WIDTH-1:0]   roi_row_start,
  input  logic [DIM_WIDTH-1:0]   roi_num_rows,
  input  logic [DIM_WIDTH-1:0]   roi_col_start,
  input  logic [DIM_WIDTH-1:0]   roi_num_cols,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0]  datai,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]  datao,
  output logic [DIM_WIDTH-1:0]   out_rows,
  output logic [DIM_WIDTH-1:0]   out_cols
);

  // Data type codes, same values as the shared dtypes table.
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START  = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END    = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START    = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END      = DTYPE_WIDTH'(4);
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL        = DTYPE_WIDTH'(5);

  localparam logic [DIM_WIDTH-1:0] DIM_ONE = DIM_WIDTH'(1);

  function automatic logic [DIM_WIDTH-1:0] sat_inc(input logic [DIM_WIDTH-1:0] v);
    return (&v) ? v : v + DIM_ONE;
  endfunction

  // Shadow window registers, loaded at FRAME_START.
  logic                 enable_f_q, enable_f_d;
  logic [DIM_WIDTH-1:0] rs_q, rs_d, nr_q, nr_d, cs_q, cs_d, nc_q, nc_d;

  // Position and emitted-beat counters.
  logic [DIM_WIDTH-1:0] row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic [DIM_WIDTH-1:0] ocol_cnt_q, ocol_cnt_d, orow_cnt_q, orow_cnt_d;
  logic [DIM_WIDTH-1:0] out_rows_q, out_rows_d, out_cols_q, out_cols_d;

  // Registered output beat.
  logic                   dvo_q, dvo_d;
  logic [DTYPE_WIDTH-1:0] dtypeo_q, dtypeo_d;
  logic [DATA_WIDTH-1:0]  datao_q, datao_d;

  logic                 row_in, col_in, keep;
  logic [DIM_WIDTH:0]   row_end_x, col_end_x;
  logic [DIM_WIDTH-1:0] rel_row;

  // Window membership of the current beat; sums carry an extra bit so a
  // window running past the counter range cannot wrap.
  always_comb begin
    row_end_x = {1'b0, rs_q} + {1'b0, nr_q};
    col_end_x = {1'b0, cs_q} + {1'b0, nc_q};
    row_in    = (row_cnt_q >= rs_q) && ({1'b0, row_cnt_q} < row_end_x);
    col_in    = (col_cnt_q >= cs_q) && ({1'b0, col_cnt_q} < col_end_x);
    rel_row   = row_cnt_q - rs_q;
  end

  // Forward/drop decision for the incoming beat.
  always_comb begin
    keep = 1'b0;
    if (dvi) begin
      case (dtypei)
        DTYPE_ROW_START, DTYPE_ROW_END: keep = !enable_f_q || row_in;
        DTYPE_PIXEL:                    keep = !enable_f_q || (row_in && col_in);
        default:                        keep = 1'b1;
      endcase
    end
  end

  // Output beat: zeros on bubbles, renumbered index on kept ROW_START.
  always_comb begin
    dvo_d    = keep;
    dtypeo_d = '0;
    datao_d  = '0;
    if (keep) begin
      dtypeo_d = dtypei;
      if (enable_f_q && (dtypei == DTYPE_ROW_START))
        datao_d = DATA_WIDTH'(rel_row);
      else
        datao_d = datai;
    end
  end

  // Shadow load, counter updates and frame statistics.
  always_comb begin
    enable_f_d = enable_f_q;
    rs_d       = rs_q;
    nr_d       = nr_q;
    cs_d       = cs_q;
    nc_d       = nc_q;
    row_cnt_d  = row_cnt_q;
    col_cnt_d  = col_cnt_q;
    ocol_cnt_d = ocol_cnt_q;
    orow_cnt_d = orow_cnt_q;
    out_rows_d = out_rows_q;
    out_cols_d = out_cols_q;
    if (dvi) begin
      case (dtypei)
        DTYPE_FRAME_START: begin
          enable_f_d = enable;
          rs_d       = roi_row_start;
          nr_d       = roi_num_rows;
          cs_d       = roi_col_start;
          nc_d       = roi_num_cols;
          row_cnt_d  = '0;
          col_cnt_d  = '0;
          ocol_cnt_d = '0;
          orow_cnt_d = '0;
        end
        DTYPE_FRAME_END: begin
          out_rows_d = orow_cnt_q;
          out_cols_d = ocol_cnt_q;
        end
        DTYPE_ROW_START: begin
          col_cnt_d = '0;
          // Only an emitted row restarts the emitted-pixel count, so that
          // trailing dropped rows leave the last emitted row's width intact.
          if (keep) ocol_cnt_d = '0;
        end
        DTYPE_ROW_END: begin
          row_cnt_d = sat_inc(row_cnt_q);
          if (keep) orow_cnt_d = sat_inc(orow_cnt_q);
        end
        DTYPE_PIXEL: begin
          col_cnt_d = sat_inc(col_cnt_q);
          if (keep) ocol_cnt_d = sat_inc(ocol_cnt_q);
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clki or negedge resetb_clki) begin
    if (!resetb_clki) begin
      enable_f_q <= 1'b0;
      rs_q       <= '0;
      nr_q       <= '0;
      cs_q       <= '0;
      nc_q       <= '0;
      row_cnt_q  <= '0;
      col_cnt_q  <= '0;
      ocol_cnt_q <= '0;
      orow_cnt_q <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      dvo_q      <= 1'b0;
      dtypeo_q   <= '0;
      datao_q    <= '0;
    end else begin
      enable_f_q <= enable_f_d;
      rs_q       <= rs_d;
      nr_q       <= nr_d;
      cs_q       <= cs_d;
      nc_q       <= nc_d;
      row_cnt_q  <= row_cnt_d;
      col_cnt_q  <= col_cnt_d;
      ocol_cnt_q <= ocol_cnt_d;
      orow_cnt_q <= orow_cnt_d;
      out_rows_q <= out_rows_d;
      out_cols_q <= out_cols_d;
      dvo_q      <= dvo_d;
      dtypeo_q   <= dtypeo_d;
      datao_q    <= datao_d;
    end
  end

  assign dvo      = dvo_q;
  assign dtypeo   = dtypeo_q;
  assign datao    = datao_q;
  assign out_rows = out_rows_q;
  assign out_cols = out_cols_q;

endmodule

// File: tb/tb_imager_roi_crop.sv
// Scoreboard bench for imager_roi_crop: a frame-level reference model
// predicts each emitted beat; a negedge monitor pops and compares.
module tb_imager_roi_crop;

  localparam logic [3:0] FS = 4'd1, FE = 4'd2, RS = 4'd3, RE = 4'd4, PX = 4'd5;
  localparam logic [3:0] HS = 4'd6, HD = 4'd7, HE = 4'd8;

  logic        clki = 1'b0;
  logic        resetb_clki = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] roi_row_start = '0, roi_num_rows = '0, roi_col_start = '0, roi_num_cols = '0;
  logic        dvi = 1'b0;
  logic [3:0]  dtypei = '0;
  logic [15:0] datai = '0;
  logic        dvo;
  logic [3:0]  dtypeo;
  logic [15:0] datao, out_rows, out_cols;

  imager_roi_crop #(.DATA_WIDTH(16), .DIM_WIDTH(16), .DTYPE_WIDTH(4)) dut (
    .clki(clki), .resetb_clki(resetb_clki), .enable(enable),
    .roi_row_start(roi_row_start), .roi_num_rows(roi_num_rows),
    .roi_col_start(roi_col_start), .roi_num_cols(roi_num_cols),
    .dvi(dvi), .dtypei(dtypei), .datai(datai),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao),
    .out_rows(out_rows), .out_cols(out_cols));

  always #5 clki = ~clki;

  int cyc = 0;
  always @(posedge clki) cyc++;

  int checks = 0, failures = 0;
  bit rst_active = 1'b1;

  typedef struct {
    logic [3:0]  dt;
    logic [15:0] d;
    int          due;
    bit          fe;
    int          er;
    int          ec;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: current image position plus emitted row/pixel tallies.
  bit m_en;
  int m_rs, m_nr, m_cs, m_nc, m_row, m_col, m_ocol, m_orow;

  function automatic void model_reset();
    m_en = 0; m_rs = 0; m_nr = 0; m_cs = 0; m_nc = 0;
    m_row = 0; m_col = 0; m_ocol = 0; m_orow = 0;
  endfunction

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  function automatic void model_beat(input logic [3:0] dt, input logic [15:0] d);
    bit   rin, cin, kept;
    exp_t e;
    rin  = (m_row >= m_rs) && (m_row < m_rs + m_nr);
    cin  = (m_col >= m_cs) && (m_col < m_cs + m_nc);
    kept = 1;
    e.dt = dt; e.d = d; e.due = cyc + 1; e.fe = 0; e.er = 0; e.ec = 0;
    case (dt)
      FS: begin
        m_en = enable; m_rs = roi_row_start; m_nr = roi_num_rows;
        m_cs = roi_col_start; m_nc = roi_num_cols;
        m_row = 0; m_col = 0; m_ocol = 0; m_orow = 0;
      end
      FE: begin e.fe = 1; e.er = m_orow; e.ec = m_ocol; end
      RS: begin
        kept = !m_en || rin;
        if (m_en) e.d = 16'(m_row - m_rs);
        if (kept) m_ocol = 0;
        m_col = 0;
      end
      RE: begin
        kept = !m_en || rin;
        if (kept) m_orow = sat(m_orow);
        m_row = sat(m_row);
      end
      PX: begin
        kept = !m_en || (rin && cin);
        if (kept) m_ocol = sat(m_ocol);
        m_col = sat(m_col);
      end
      default: ;
    endcase
    if (kept) q.push_back(e);
  endfunction

  // Monitor: every output slot is either a predicted beat or an all-zero bubble.
  always @(negedge clki) begin
    if (!rst_active) begin
      if (dvo) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", {28'h0, dtypeo}, 32'hffff_ffff);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("dtypeo", {28'h0, dtypeo}, {28'h0, e.dt});
          chk("datao", {16'h0, datao}, {16'h0, e.d});
          chk("latency_cycle", cyc, e.due);
          if (e.fe) begin
            chk("out_rows_at_fe", {16'h0, out_rows}, e.er);
            chk("out_cols_at_fe", {16'h0, out_cols}, e.ec);
          end
        end
      end else begin
        chk("bubble_zero", {12'h0, dtypeo, datao}, 32'h0);
        if (q.size() > 0 && q[0].due <= cyc) begin
          chk("missing_beat", {28'h0, q[0].dt}, 32'hffff_ffff);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [3:0] dt, input logic [15:0] d);
    @(posedge clki); #1;
    dvi = 1'b1; dtypei = dt; datai = d;
    model_beat(dt, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clki); #1;
      dvi = 1'b0; dtypei = 4'($urandom); datai = 16'($urandom);
    end
  endtask

  task automatic set_cfg(input bit en, input int rs, input int nr, input int cs, input int nc);
    enable = en; roi_row_start = 16'(rs); roi_num_rows = 16'(nr);
    roi_col_start = 16'(cs); roi_num_cols = 16'(nc);
  endtask

  task automatic send_header();
    beat(HS, 16'($urandom));
    for (int i = 0; i < 3; i++) beat(HD, 16'($urandom));
    beat(HE, 16'($urandom));
    beat(4'hf, 16'($urandom));
    beat(4'h0, 16'($urandom));
  endtask

  // One frame; pixel value 16*row+col unless rnd; cfg_row >= 0 re-randomises
  // the config inputs at the end of that row.
  task automatic send_frame(input int rows, input int cols, input bit rnd,
                            input bit skip_rs, input bit skip_re,
                            input int cfg_row, input bit gaps);
    beat(FS, 16'($urandom));
    for (int r = 0; r < rows; r++) begin
      if (!(skip_rs && r == 0)) beat(RS, 16'(r));
      for (int c = 0; c < cols; c++) begin
        beat(PX, rnd ? 16'($urandom) : 16'(16 * r + c));
        if (gaps && $urandom_range(3) == 0) idle(1);
      end
      if (!(skip_re && r == rows - 1)) beat(RE, 16'(r));
      if (r == cfg_row)
        set_cfg($urandom_range(1), $urandom_range(5), $urandom_range(5),
                $urandom_range(7), $urandom_range(7));
    end
    beat(FE, 16'($urandom));
    idle(2);
  endtask

  initial begin
    model_reset();
    #12;
    chk("reset_dvo", {31'h0, dvo}, 32'h0);
    chk("reset_out_rows", {16'h0, out_rows}, 32'h0);
    chk("reset_out_cols", {16'h0, out_cols}, 32'h0);
    @(posedge clki); #1;
    resetb_clki = 1'b1;
    rst_active = 1'b0;
    idle(2);

    // Before any FRAME_START the stage is in bypass.
    beat(RS, 16'h55); beat(PX, 16'h1234); beat(RE, 16'h0);
    idle(2);

    set_cfg(1, 0, 4, 0, 6);
    send_frame(4, 6, 0, 0, 0, -1, 0);
    chk("full_out_rows", {16'h0, out_rows}, 32'd4);
    chk("full_out_cols", {16'h0, out_cols}, 32'd6);

    set_cfg(1, 1, 2, 2, 3);
    send_frame(4, 6, 0, 0, 0, -1, 1);
    chk("crop_out_rows", {16'h0, out_rows}, 32'd2);
    chk("crop_out_cols", {16'h0, out_cols}, 32'd3);

    set_cfg(1, 3, 10, 4, 10);
    send_frame(4, 6, 0, 0, 0, -1, 0);
    chk("edge_out_rows", {16'h0, out_rows}, 32'd1);
    chk("edge_out_cols", {16'h0, out_cols}, 32'd2);

    set_cfg(1, 0, 4, 0, 6);
    send_frame(4, 6, 0, 1, 1, -1, 0);
    chk("missing_out_rows", {16'h0, out_rows}, 32'd3);
    chk("missing_out_cols", {16'h0, out_cols}, 32'd6);

    // Mid-frame config change must not disturb the running frame.
    set_cfg(1, 1, 2, 2, 3);
    send_frame(4, 6, 0, 0, 0, -1, 0);
    send_header();
    set_cfg(1, 1, 2, 2, 3);
    beat(FS, 16'h0);
    beat(RS, 16'h0);
    for (int c = 0; c < 6; c++) beat(PX, 16'(c));
    beat(RE, 16'h0);
    set_cfg(1, 0, 4, 0, 6);
    for (int r = 1; r < 4; r++) begin
      beat(RS, 16'(r));
      for (int c = 0; c < 6; c++) beat(PX, 16'(16 * r + c));
      beat(RE, 16'(r));
    end
    beat(FE, 16'h0);
    idle(2);
    chk("midcfg_out_rows", {16'h0, out_rows}, 32'd2);
    chk("midcfg_out_cols", {16'h0, out_cols}, 32'd3);
    send_frame(4, 6, 0, 0, 0, -1, 0);
    chk("newcfg_out_rows", {16'h0, out_rows}, 32'd4);

    set_cfg(0, 1, 1, 1, 1);
    send_frame(4, 6, 1, 0, 0, -1, 1);
    chk("bypass_out_rows", {16'h0, out_rows}, 32'd4);
    chk("bypass_out_cols", {16'h0, out_cols}, 32'd6);

    // Async reset in the middle of an emitted row.
    set_cfg(0, 0, 0, 0, 0);
    beat(FS, 16'h0); beat(RS, 16'h0); beat(PX, 16'h11); beat(PX, 16'h22);
    @(posedge clki); #2;
    rst_active = 1'b1;
    resetb_clki = 1'b0;
    dvi = 1'b0;
    #1;
    chk("midrow_reset_dvo", {31'h0, dvo}, 32'h0);
    chk("midrow_reset_data", {12'h0, dtypeo, datao}, 32'h0);
    chk("midrow_reset_out_rows", {16'h0, out_rows}, 32'h0);
    q.delete();
    model_reset();
    @(posedge clki); @(posedge clki); #1;
    resetb_clki = 1'b1;
    rst_active = 1'b0;
    set_cfg(1, 1, 1, 1, 1);
    for (int c = 2; c < 5; c++) beat(PX, 16'(c));
    beat(RE, 16'h0); beat(RS, 16'h1); beat(PX, 16'h7); beat(RE, 16'h1);
    beat(FE, 16'h0);
    idle(2);
    chk("postreset_bypass_rows", {16'h0, out_rows}, 32'd2);
    send_frame(3, 3, 0, 0, 0, -1, 0);
    chk("postreset_crop_rows", {16'h0, out_rows}, 32'd1);
    chk("postreset_crop_cols", {16'h0, out_cols}, 32'd1);

    // Randomised frames against the model.
    for (int f = 0; f < 40; f++) begin
      set_cfg($urandom_range(3) != 0, $urandom_range(5), $urandom_range(5),
              $urandom_range(7), $urandom_range(7));
      send_frame($urandom_range(6, 1), $urandom_range(8, 1), 1,
                 $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(1) ? int'($urandom_range(5)) : -1,
                 $urandom_range(1));
      if ($urandom_range(2) == 0) send_header();
    end

    idle(4);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
